// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath width, bubble encoding and the fetch payload.
package mips_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instruction;
    } fetch_pkt_t;

endpackage : mips_pkg

// File: rtl/if_id_queue_mem.sv
// Small register-array storage for the IF/ID queue; one write port, one asynchronous read port.
module if_id_queue_mem #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned ADDR_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : if_id_queue_mem

// File: rtl/if_id_queue.sv
// In-order {pc, instruction} queue decoupling IF from ID, with full back-pressure and branch flush.
module if_id_queue
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_instruction,
    input  logic              in_valid,
    output logic              if_freez,
    input  logic              flush,
    input  logic              id_stall,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instruction,
    output logic              out_valid,
    output logic [PTR_W:0]    count
);

    localparam int unsigned ENTRY_W = 2 * DATA_W;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               push_c, pop_c;
    logic [ENTRY_W-1:0] rd_data_c;

    // Freeze depends only on registered occupancy, so no IF<->ID combinational loop exists.
    assign if_freez  = (count_q == (PTR_W+1)'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push_c    = in_valid & ~if_freez & ~flush;
    assign pop_c     = out_valid & ~id_stall & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    if_id_queue_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (ENTRY_W),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst),
        .wr_en_i   (push_c),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i ({in_pc, in_instruction}),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data_c)
    );

    // Empty queue presents a bubble to ID rather than stale storage.
    assign out_pc          = out_valid ? rd_data_c[ENTRY_W-1:DATA_W] : '0;
    assign out_instruction = out_valid ? rd_data_c[DATA_W-1:0] : DATA_W'(NOP_INSTR);
    assign count           = count_q;

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// Directed vector bench for if_id_queue: table-driven flow cases plus reset, wrap and async-reset sequences.
module tb_if_id_queue;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_pc, in_instruction;
    logic        in_valid, flush, id_stall;
    logic        if_freez, out_valid;
    logic [31:0] out_pc, out_instruction;
    logic [1:0]  count;

    int total = 0;
    int bad   = 0;

    if_id_queue dut (
        .clk             (clk),
        .rst             (rst),
        .in_pc           (in_pc),
        .in_instruction  (in_instruction),
        .in_valid        (in_valid),
        .if_freez        (if_freez),
        .flush           (flush),
        .id_stall        (id_stall),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .out_valid       (out_valid),
        .count           (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        fetch_pkt_t  pkt;
        logic        fl;
        logic        stall;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [1:0]  e_count;
        logic        e_freez;
    } vec_t;

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return 32'h2400_0000 | pc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_valid, input logic [31:0] e_pc,
                           input logic [1:0] e_count, input logic e_freez);
        chk({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
        chk({tag, ".pc"},    out_pc,         e_valid ? e_pc : 32'h0);
        chk({tag, ".instr"}, out_instruction, e_valid ? ins_of(e_pc) : NOP_INSTR);
        chk({tag, ".count"}, 32'(count),     32'(e_count));
        chk({tag, ".freez"}, 32'(if_freez),  32'(e_freez));
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic fl, input logic st);
        in_valid       = v;
        in_pc          = pc;
        in_instruction = ins_of(pc);
        flush          = fl;
        id_stall       = st;
    endtask

    vec_t vecs[15];

    function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic fl, input logic st,
                                input logic ev, input logic [31:0] epc, input logic [1:0] ec,
                                input logic ef);
        vec_t r;
        r.valid = v; r.pkt.pc = pc; r.pkt.instruction = ins_of(pc); r.fl = fl; r.stall = st;
        r.e_valid = ev; r.e_pc = epc; r.e_count = ec; r.e_freez = ef;
        return r;
    endfunction

    initial begin
        // Expected values describe outputs just after the edge that consumes each vector.
        vecs[0]  = mk(1, 32'h00, 0, 0, 1, 32'h00, 2'd1, 0);
        vecs[1]  = mk(1, 32'h04, 0, 0, 1, 32'h04, 2'd1, 0);
        vecs[2]  = mk(1, 32'h08, 0, 0, 1, 32'h08, 2'd1, 0);
        vecs[3]  = mk(0, 32'h00, 0, 0, 0, 32'h00, 2'd0, 0);
        vecs[4]  = mk(1, 32'h10, 0, 1, 1, 32'h10, 2'd1, 0);
        vecs[5]  = mk(1, 32'h14, 0, 1, 1, 32'h10, 2'd2, 1);
        vecs[6]  = mk(1, 32'h18, 0, 1, 1, 32'h10, 2'd2, 1);
        vecs[7]  = mk(0, 32'h00, 0, 0, 1, 32'h14, 2'd1, 0);
        vecs[8]  = mk(0, 32'h00, 0, 0, 0, 32'h00, 2'd0, 0);
        vecs[9]  = mk(1, 32'h40, 0, 1, 1, 32'h40, 2'd1, 0);
        vecs[10] = mk(1, 32'h44, 0, 1, 1, 32'h40, 2'd2, 1);
        vecs[11] = mk(1, 32'h20, 1, 0, 0, 32'h00, 2'd0, 0);
        vecs[12] = mk(0, 32'h00, 0, 0, 0, 32'h00, 2'd0, 0);
        vecs[13] = mk(1, 32'h50, 0, 0, 1, 32'h50, 2'd1, 0);
        vecs[14] = mk(0, 32'h00, 0, 0, 0, 32'h00, 2'd0, 0);

        // Reset held low while fetch keeps presenting pairs.
        rst = 1'b0;
        drive(1, 32'h100, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_all($sformatf("rst_hold%0d", i), 0, 32'h0, 2'd0, 0);
        end
        rst = 1'b1;
        drive(0, 32'h0, 0, 0);
        @(posedge clk); #1;
        chk_all("rst_release", 0, 32'h0, 2'd0, 0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].valid, vecs[i].pkt.pc, vecs[i].fl, vecs[i].stall);
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_count,
                    vecs[i].e_freez);
        end

        // Simultaneous push/pop at occupancy 1, long enough to wrap both pointers repeatedly.
        drive(1, 32'h30, 0, 1);
        @(posedge clk); #1;
        chk_all("pp_seed", 1, 32'h30, 2'd1, 0);
        for (int k = 0; k < 10; k++) begin
            drive(1, 32'h34 + 32'(4 * k), 0, 0);
            @(posedge clk); #1;
            chk_all($sformatf("pp%0d", k), 1, 32'h34 + 32'(4 * k), 2'd1, 0);
        end
        drive(0, 32'h0, 0, 0);
        @(posedge clk); #1;
        chk_all("pp_drain", 0, 32'h0, 2'd0, 0);

        // Asynchronous reset between edges with a full queue.
        drive(1, 32'h60, 0, 1);
        @(posedge clk); #1;
        drive(1, 32'h64, 0, 1);
        @(posedge clk); #1;
        chk_all("ar_full", 1, 32'h60, 2'd2, 1);
        drive(0, 32'h0, 0, 1);
        #1 rst = 1'b0;
        #1;
        chk_all("ar_async", 0, 32'h0, 2'd0, 0);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk_all("ar_after", 0, 32'h0, 2'd0, 0);
        drive(1, 32'h70, 0, 0);
        @(posedge clk); #1;
        chk_all("ar_refill", 1, 32'h70, 2'd1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_if_id_queue
